risc_iunit: RTL and testbench

Instruction unit (fetch/decode front end) of the 13-bit RISC core. Each clock it holds a program counter, latches the presented instruction word into the instruction register (IR) and advances the PC. It decodes the IR into opcode, register fields and a one-hot ALU-operation select for the datapath.

---
 rtl/risc_iunit.sv | 63 ++++++
 tb/tb_risc_iunit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/risc_iunit.sv
// Instruction unit of the 13-bit RISC core: PC, instruction register and
// combinational decode of the IR into register fields and a one-hot ALU select.
module risc_iunit #(
    parameter int PC_WIDTH = 5,
    parameter int IW       = 13
) (
    input  logic                clk,
    input  logic                rst_n,        // active-high despite the name
    input  logic [IW-1:0]       instruction,
    output logic [PC_WIDTH-1:0] pc,
    output logic [IW-1:0]       ir,
    output logic [3:0]          opcode,
    output logic [2:0]          rd,
    output logic [2:0]          rs1,
    output logic [2:0]          rs2,
    output logic [12:0]         op_sel,
    output logic                uses_rs2,
    output logic                illegal
);

    logic [PC_WIDTH-1:0] r_pc;
    logic [IW-1:0]       r_ir;
    logic [3:0]          w_opcode;
    logic [12:0]         w_op_sel;
    logic                w_uses_rs2;
    logic                w_illegal;

    // PC wraps naturally at 2**PC_WIDTH; an asserted reset drops the in-flight word.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_pc <= '0;
            r_ir <= '0;
        end else begin
            r_pc <= r_pc + PC_WIDTH'(1);
            r_ir <= instruction;
        end
    end

    assign w_opcode = r_ir[12:9];

    always_comb begin
        w_op_sel   = '0;
        w_uses_rs2 = 1'b0;
        w_illegal  = 1'b0;
        if (w_opcode >= 4'd14) begin
            w_illegal = 1'b1;
        end else if (w_opcode != 4'd0) begin
            w_op_sel   = 13'd1 << (w_opcode - 4'd1);
            w_uses_rs2 = (w_opcode <= 4'd5);
        end
    end

    assign pc       = r_pc;
    assign ir       = r_ir;
    assign opcode   = w_opcode;
    assign rd       = r_ir[8:6];
    assign rs1      = r_ir[5:3];
    assign rs2      = r_ir[2:0];
    assign op_sel   = w_op_sel;
    assign uses_rs2 = w_uses_rs2;
    assign illegal  = w_illegal;

endmodule

// File: tb/tb_risc_iunit.sv
// Self-checking bench for risc_iunit: directed fetch/decode sequence, illegal
// opcodes, PC wrap, asynchronous reset and randomized words against a model.
module tb_risc_iunit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [12:0] instruction = '0;
    logic [4:0]  pc;
    logic [12:0] ir;
    logic [3:0]  opcode;
    logic [2:0]  rd, rs1, rs2;
    logic [12:0] op_sel;
    logic        uses_rs2, illegal;

    int checks   = 0;
    int failures = 0;
    int exp_pc   = 0;
    int exp_ir   = 0;

    risc_iunit dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction),
        .pc(pc), .ir(ir), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .op_sel(op_sel), .uses_rs2(uses_rs2), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Reference decode from the opcode map, using plain arithmetic on the word.
    function automatic logic [40:0] model_decode(input int w);
        int op, f_rd, f_rs1, f_rs2, sel;
        logic u, ill;
        op    = w / 512;
        f_rd  = (w / 64) % 8;
        f_rs1 = (w / 8) % 8;
        f_rs2 = w % 8;
        sel   = (op >= 1 && op <= 13) ? (2 ** (op - 1)) : 0;
        u     = (op >= 1 && op <= 5);
        ill   = (op >= 14);
        return {13'(w), 4'(op), 3'(f_rd), 3'(f_rs1), 3'(f_rs2), 13'(sel), u, ill};
    endfunction

    function automatic logic [40:0] dut_vec();
        return {ir, opcode, rd, rs1, rs2, op_sel, uses_rs2, illegal};
    endfunction

    // Present a word, take one edge, update the model, land on the falling edge.
    task automatic step(input logic [12:0] w);
        instruction = w;
        @(posedge clk);
        if (!rst_n) begin
            exp_ir = int'(w);
            exp_pc = (exp_pc + 1) % 32;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b1;
        exp_pc = 0;
        exp_ir = 0;
        #1 rst_n = 1'b0;
    endtask

    task automatic test_reset();
        instruction = 13'h0208;
        rst_n = 1'b1;
        #2;
        checks++;
        if (pc !== 5'd0) begin failures++; $display("FAIL reset_pc got=%0d exp=0", pc); end
        checks++;
        if (dut_vec() !== 41'd0) begin failures++; $display("FAIL reset_decode got=%h exp=0", dut_vec()); end
        #1 rst_n = 1'b0;
        exp_pc = 0;
        exp_ir = 0;
    endtask

    task automatic test_first_fetch();
        step(13'h0208);
        checks++;
        if (pc !== 5'd1) begin failures++; $display("FAIL first_pc got=%0d exp=1", pc); end
        checks++;
        if ({ir, opcode, rd, rs1, rs2, op_sel, uses_rs2} !== {13'h0208, 4'd1, 3'd0, 3'd1, 3'd0, 13'h0001, 1'b1}) begin
            failures++;
            $display("FAIL first_decode got ir=%h op=%0d rd=%0d rs1=%0d rs2=%0d sel=%h u=%b", ir, opcode, rd, rs1, rs2, op_sel, uses_rs2);
        end
    endtask

    task automatic test_sequence();
        logic [12:0] seq [12] = '{13'h05f1, 13'h06aa, 13'h08e3, 13'h0b24, 13'h0d45, 13'h0f86,
                                  13'h11c7, 13'h1200, 13'h1441, 13'h1682, 13'h18c3, 13'h1b04};
        for (int i = 0; i < 12; i++) begin
            step(seq[i]);
            checks++;
            if (pc !== 5'(i + 2) || opcode !== 4'(i + 2)) begin
                failures++;
                $display("FAIL seq_pc_op[%0d] got pc=%0d op=%0d exp pc=%0d op=%0d", i, pc, opcode, i + 2, i + 2);
            end
            checks++;
            if (uses_rs2 !== (i < 4)) begin
                failures++;
                $display("FAIL seq_uses_rs2[%0d] got=%b exp=%b", i, uses_rs2, (i < 4));
            end
            checks++;
            if (dut_vec() !== model_decode(exp_ir)) begin
                failures++;
                $display("FAIL seq_decode[%0d] got=%h exp=%h", i, dut_vec(), model_decode(exp_ir));
            end
            if (i == 0) begin
                checks++;
                if ({rd, rs1, rs2} !== {3'd7, 3'd6, 3'd1}) begin
                    failures++;
                    $display("FAIL seq_fields got rd=%0d rs1=%0d rs2=%0d exp 7 6 1", rd, rs1, rs2);
                end
            end
        end
    endtask

    task automatic test_illegal();
        logic [12:0] words [2] = '{13'h1c00, 13'h1fff};
        for (int i = 0; i < 2; i++) begin
            step(words[i]);
            checks++;
            if (illegal !== 1'b1 || op_sel !== 13'd0 || uses_rs2 !== 1'b0) begin
                failures++;
                $display("FAIL illegal[%0d] got ill=%b sel=%h u=%b exp ill=1 sel=0 u=0", i, illegal, op_sel, uses_rs2);
            end
            checks++;
            if (pc !== 5'(exp_pc)) begin failures++; $display("FAIL illegal_pc[%0d] got=%0d exp=%0d", i, pc, exp_pc); end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            step(13'($urandom_range(0, 8191)));
            checks++;
            if (pc !== 5'(exp_pc) || dut_vec() !== model_decode(exp_ir)) begin
                failures++;
                $display("FAIL wrap[%0d] got pc=%0d vec=%h exp pc=%0d vec=%h", i, pc, dut_vec(), exp_pc, model_decode(exp_ir));
            end
        end
        checks++;
        if (pc !== 5'd0) begin failures++; $display("FAIL wrap_zero got=%0d exp=0", pc); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            step(13'($urandom_range(0, 8191)));
            checks++;
            if (pc !== 5'(exp_pc) || dut_vec() !== model_decode(exp_ir)) begin
                failures++;
                $display("FAIL random[%0d] got pc=%0d vec=%h exp pc=%0d vec=%h", i, pc, dut_vec(), exp_pc, model_decode(exp_ir));
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 9; i++) step(13'($urandom_range(0, 8191)));
        checks++;
        if (pc !== 5'd9) begin failures++; $display("FAIL pre_reset_pc got=%0d exp=9", pc); end
        instruction = 13'h0a49;
        #2 rst_n = 1'b1;
        exp_pc = 0;
        exp_ir = 0;
        #1;
        checks++;
        if (pc !== 5'd0 || ir !== 13'd0) begin
            failures++;
            $display("FAIL mid_reset got pc=%0d ir=%h exp pc=0 ir=0", pc, ir);
        end
        @(posedge clk);
        #1;
        checks++;
        if (pc !== 5'd0 || dut_vec() !== 41'd0) begin
            failures++;
            $display("FAIL reset_held got pc=%0d vec=%h exp 0", pc, dut_vec());
        end
        #1 rst_n = 1'b0;
        @(negedge clk);
        step(13'h0e91);
        checks++;
        if (pc !== 5'd1 || dut_vec() !== model_decode(13'h0e91)) begin
            failures++;
            $display("FAIL post_release got pc=%0d vec=%h exp pc=1 vec=%h", pc, dut_vec(), model_decode(13'h0e91));
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_sequence();
        test_illegal();
        test_wrap();
        test_random();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
